fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/fetch_buf.sv | 74 +++++++
 rtl/fetch_ctrl.sv | 117 +++++++++++
 tb/tb_fetch_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller and its buffer.
package fetch_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned FETCH_BUF_DEPTH = 2;
  localparam int unsigned FETCH_BUF_CNT_W = 2;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Head contents presented to decode while the buffer is empty.
  localparam fetch_entry_t EMPTY_ENTRY = '{pc: '0, instr: NOP_INSTR};

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry instruction FIFO; slot 0 is always the head so decode sees flopped data.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  input  logic                       flush,
  output logic [FETCH_BUF_CNT_W-1:0] count,
  output logic                       head_valid,
  output fetch_entry_t               head
);

  localparam logic [FETCH_BUF_CNT_W-1:0] CNT_ONE  = FETCH_BUF_CNT_W'(1);
  localparam logic [FETCH_BUF_CNT_W-1:0] CNT_FULL = FETCH_BUF_CNT_W'(FETCH_BUF_DEPTH);

  fetch_entry_t                 slot1;
  fetch_entry_t                 head_next;
  fetch_entry_t                 slot1_next;
  logic [FETCH_BUF_CNT_W-1:0]   count_next;
  logic                         pop_eff;

  assign pop_eff = pop & head_valid;

  // Flush wins over everything; otherwise shift on pop, fill the first free slot on push.
  always_comb begin
    head_next  = head;
    slot1_next = slot1;
    count_next = count;
    if (flush) begin
      head_next  = EMPTY_ENTRY;
      count_next = '0;
    end else if (push && pop_eff) begin
      if (count == CNT_ONE) begin
        head_next = push_entry;
      end else begin
        head_next  = slot1;
        slot1_next = push_entry;
      end
    end else if (pop_eff) begin
      count_next = count - CNT_ONE;
      head_next  = (count == CNT_ONE) ? EMPTY_ENTRY : slot1;
    end else if (push) begin
      count_next = count + CNT_ONE;
      if (count == '0) begin
        head_next = push_entry;
      end else begin
        slot1_next = push_entry;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head       <= EMPTY_ENTRY;
      slot1      <= '0;
      count      <= '0;
      head_valid <= 1'b0;
    end else begin
      head       <= head_next;
      slot1      <= slot1_next;
      count      <= count_next;
      head_valid <= (count_next != '0);
    end
  end

  // The fetch credit scheme must never let a push land on a full buffer.
  assert property (@(posedge clk) disable iff (reset)
    !(push && !pop_eff && !flush && count == CNT_FULL))
    else $error("fetch_buf overflow");

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request, two-entry decode buffer,
// redirect handling with in-flight response dropping.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc_out
);

  localparam logic [FETCH_BUF_CNT_W-1:0] BUF_FULL = FETCH_BUF_CNT_W'(FETCH_BUF_DEPTH);

  fetch_state_e               state;
  fetch_state_e               state_next;
  logic [XLEN-1:0]            fetch_pc;
  logic [XLEN-1:0]            fetch_pc_next;
  logic [XLEN-1:0]            req_pc;
  logic [XLEN-1:0]            req_pc_next;
  logic                       push;
  logic                       flush;
  logic                       pop;
  logic [FETCH_BUF_CNT_W-1:0] buf_count;
  logic                       head_valid;
  fetch_entry_t               head;
  fetch_entry_t               push_entry;

  assign pop        = head_valid & instr_ready;
  assign push_entry = '{pc: req_pc, instr: resp_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      fetch_pc <= word_align(RESET_PC);
      req_pc   <= '0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      req_pc   <= req_pc_next;
    end
  end

  // req_valid is combinational so a redirect suppresses the handshake in the same cycle.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    req_pc_next   = req_pc;
    push          = 1'b0;
    flush         = 1'b0;
    req_valid     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        state_next = ST_REQ;
      end
      ST_REQ: begin
        req_valid = (buf_count < BUF_FULL) && !redirect_valid;
        if (req_valid && req_ready) begin
          req_pc_next   = fetch_pc;
          fetch_pc_next = fetch_pc + XLEN'(4);
          state_next    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          state_next = resp_valid ? ST_REQ : ST_DROP;
        end else if (resp_valid) begin
          push       = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_DROP: begin
        // The response owed to the abandoned request ends the drop even if redirected again.
        if (resp_valid) begin
          state_next = ST_REQ;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (redirect_valid) begin
      fetch_pc_next = word_align(redirect_pc);
      flush         = 1'b1;
    end
  end

  fetch_buf u_fetch_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .count      (buf_count),
    .head_valid (head_valid),
    .head       (head)
  );

  assign req_addr    = fetch_pc;
  assign instr_valid = head_valid;
  assign instr       = head.instr;
  assign pc_out      = head.pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: sequencing, stall, redirects, alignment/wrap and reset.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        req_valid;
  logic        req_ready = 1'b1;
  logic [31:0] req_addr;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr;
  logic [31:0] pc_out;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic mem_auto = 1'b1;

  logic [31:0] got_addr[$];
  logic [31:0] got_instr[$];
  logic [31:0] got_pc[$];
  int          got_cyc[$];

  fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .pc_out         (pc_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0013;
      32'h4:   return 32'h0010_8093;
      32'h8:   return 32'h0021_0113;
      default: return 32'hA000_0000 | a;
    endcase
  endfunction

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  // One clock: log handshakes/pops seen before the edge, then model a 1-cycle memory.
  task automatic tick();
    logic hs;
    logic [31:0] a;
    #1;
    hs = req_valid && req_ready;
    a  = req_addr;
    if (instr_valid && instr_ready) begin
      got_instr.push_back(instr);
      got_pc.push_back(pc_out);
      got_cyc.push_back(cyc);
    end
    if (hs) got_addr.push_back(a);
    @(posedge clk);
    #1;
    cyc++;
    if (mem_auto) begin
      resp_valid = hs;
      resp_data  = hs ? mem_word(a) : 32'h0;
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    req_ready      = 1'b1;
    resp_valid     = 1'b0;
    resp_data      = '0;
    instr_ready    = 1'b1;
    mem_auto       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    got_addr.delete();
    got_instr.delete();
    got_pc.delete();
    got_cyc.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    resp_valid = 1'b1;
    resp_data  = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid: got %b want 0", req_valid); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
    n_cmp++; if (instr !== NOP) begin n_bad++; $display("FAIL reset_instr: got %h want %h", instr, NOP); end
    n_cmp++; if (pc_out !== 32'h0) begin n_bad++; $display("FAIL reset_pc_out: got %h want 0", pc_out); end
    n_cmp++; if (req_addr !== RESET_PC) begin n_bad++; $display("FAIL reset_req_addr: got %h want %h", req_addr, RESET_PC); end
    resp_valid = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr[3]  = '{32'h0, 32'h4, 32'h8};
    logic [31:0] exp_instr[3] = '{32'h0000_0013, 32'h0010_8093, 32'h0021_0113};
    do_reset();
    repeat (10) tick();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (q_at(got_addr, i) !== exp_addr[i]) begin n_bad++; $display("FAIL seq_addr[%0d]: got %h want %h", i, q_at(got_addr, i), exp_addr[i]); end
      n_cmp++; if (q_at(got_instr, i) !== exp_instr[i]) begin n_bad++; $display("FAIL seq_instr[%0d]: got %h want %h", i, q_at(got_instr, i), exp_instr[i]); end
      n_cmp++; if (q_at(got_pc, i) !== exp_addr[i]) begin n_bad++; $display("FAIL seq_pc[%0d]: got %h want %h", i, q_at(got_pc, i), exp_addr[i]); end
    end
    // addr 0 accepted in cycle 1, response in cycle 2, visible to decode in cycle 3
    n_cmp++; if (got_cyc.size() < 2 || got_cyc[0] !== 3) begin n_bad++; $display("FAIL seq_latency: first pop cycle %0d want 3", (got_cyc.size() > 0) ? got_cyc[0] : -1); end
    n_cmp++; if (got_cyc.size() < 2 || got_cyc[1] - got_cyc[0] !== 2) begin n_bad++; $display("FAIL seq_throughput: pop gap %0d want 2", (got_cyc.size() > 1) ? got_cyc[1] - got_cyc[0] : -1); end
  endtask

  task automatic test_stall();
    do_reset();
    instr_ready = 1'b0;
    repeat (12) tick();
    #1;
    n_cmp++; if (got_addr.size() !== 2) begin n_bad++; $display("FAIL stall_req_count: got %0d want 2", got_addr.size()); end
    n_cmp++; if (req_valid !== 1'b0) begin n_bad++; $display("FAIL stall_req_valid: got %b want 0", req_valid); end
    n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL stall_instr_valid: got %b want 1", instr_valid); end
    n_cmp++; if (pc_out !== 32'h0) begin n_bad++; $display("FAIL stall_head_pc: got %h want 0", pc_out); end
    instr_ready = 1'b1;
    repeat (6) tick();
    n_cmp++; if (q_at(got_addr, 2) !== 32'h8) begin n_bad++; $display("FAIL stall_resume_addr: got %h want 8", q_at(got_addr, 2)); end
    n_cmp++; if (q_at(got_instr, 0) !== 32'h0000_0013) begin n_bad++; $display("FAIL stall_instr0: got %h want 00000013", q_at(got_instr, 0)); end
    n_cmp++; if (q_at(got_instr, 1) !== 32'h0010_8093) begin n_bad++; $display("FAIL stall_instr1: got %h want 00108093", q_at(got_instr, 1)); end
    n_cmp++; if (q_at(got_pc, 1) !== 32'h4) begin n_bad++; $display("FAIL stall_pc1: got %h want 4", q_at(got_pc, 1)); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    mem_auto = 1'b0;
    tick();
    tick();
    resp_valid = 1'b1; resp_data = 32'h0000_0013;
    tick();
    resp_valid = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (req_valid !== 1'b0) begin n_bad++; $display("FAIL rdw_drop_req_valid: got %b want 0", req_valid); end
    resp_valid = 1'b1; resp_data = 32'h0010_8093;
    tick();
    resp_valid = 1'b0;
    #1;
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rdw_dropped_resp: instr_valid %b want 0", instr_valid); end
    n_cmp++; if (req_valid !== 1'b1) begin n_bad++; $display("FAIL rdw_req_valid: got %b want 1", req_valid); end
    n_cmp++; if (req_addr !== 32'h0000_0100) begin n_bad++; $display("FAIL rdw_req_addr: got %h want 00000100", req_addr); end
    tick();
    resp_valid = 1'b1; resp_data = 32'hA000_0100;
    tick();
    resp_valid = 1'b0;
    #1;
    n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL rdw_instr_valid: got %b want 1", instr_valid); end
    n_cmp++; if (pc_out !== 32'h0000_0100) begin n_bad++; $display("FAIL rdw_pc_out: got %h want 00000100", pc_out); end
    n_cmp++; if (instr !== 32'hA000_0100) begin n_bad++; $display("FAIL rdw_instr: got %h want a0000100", instr); end
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    mem_auto = 1'b0;
    tick();
    tick();
    resp_valid = 1'b1; resp_data = 32'h0000_0013;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    tick();
    resp_valid = 1'b0;
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rds_instr_valid: got %b want 0", instr_valid); end
    n_cmp++; if (req_valid !== 1'b1) begin n_bad++; $display("FAIL rds_req_valid: got %b want 1", req_valid); end
    n_cmp++; if (req_addr !== 32'h0000_0040) begin n_bad++; $display("FAIL rds_req_addr: got %h want 00000040", req_addr); end
  endtask

  task automatic test_align_wrap();
    do_reset();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
    #1;
    n_cmp++; if (req_valid !== 1'b0) begin n_bad++; $display("FAIL aw_redirect_blocks_req: got %b want 0", req_valid); end
    tick();
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (req_addr !== 32'h0000_0200) begin n_bad++; $display("FAIL aw_aligned_addr: got %h want 00000200", req_addr); end
    n_cmp++; if (req_valid !== 1'b1) begin n_bad++; $display("FAIL aw_req_valid: got %b want 1", req_valid); end
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (req_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL aw_top_addr: got %h want fffffffc", req_addr); end
    tick();
    tick();
    #1;
    n_cmp++; if (req_addr !== 32'h0000_0000) begin n_bad++; $display("FAIL aw_wrap_addr: got %h want 00000000", req_addr); end
    n_cmp++; if (pc_out !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL aw_wrap_pc_out: got %h want fffffffc", pc_out); end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    mem_auto = 1'b0;
    tick();
    tick();
    resp_valid = 1'b1; resp_data = 32'h0000_0013;
    tick();
    resp_valid = 1'b0;
    instr_ready = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_wait_instr_valid: got %b want 0", instr_valid); end
    n_cmp++; if (instr !== NOP) begin n_bad++; $display("FAIL rst_wait_instr: got %h want %h", instr, NOP); end
    n_cmp++; if (req_addr !== RESET_PC) begin n_bad++; $display("FAIL rst_wait_req_addr: got %h want %h", req_addr, RESET_PC); end
    resp_valid = 1'b1; resp_data = 32'hDEAD_0001;
    tick();
    tick();
    reset = 1'b0;
    tick();
    resp_valid = 1'b0;
    #1;
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_late_resp: instr_valid %b want 0", instr_valid); end
    n_cmp++; if (req_valid !== 1'b1) begin n_bad++; $display("FAIL rst_restart_req_valid: got %b want 1", req_valid); end
    n_cmp++; if (req_addr !== RESET_PC) begin n_bad++; $display("FAIL rst_restart_addr: got %h want %h", req_addr, RESET_PC); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_align_wrap();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
